// File: rtl/cache_refill_ctrl.sv
// Line-fill engine: accepts one cache miss, invalidates the tag, bursts the
// block-aligned line from memory into the data store, then commits a valid tag.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   miss_valid_i/ready_o    miss request handshake, miss_addr_i byte address
//   mem_req_*               burst read request (block-aligned address)
//   mem_rvalid/rdata/rlast  read beats from memory, no backpressure
//   line_*                  data store word write port
//   tag_*                   tag store write port, wdata = {valid, tag}
//   refill_done_o           one-cycle pulse when the line becomes valid
//   refill_err_o            one-cycle pulse on a burst length error
module cache_refill_ctrl #(
    parameter int WORD_NUM  = 32,
    parameter int DATA_WID  = 64,
    parameter int INDEX_WID = 10,
    parameter int ADDR_WID  = 32,
    localparam int WORD_WID = $clog2(WORD_NUM),
    localparam int OFF_WID  = $clog2(DATA_WID / 8) + WORD_WID,
    localparam int TAG_WID  = ADDR_WID - INDEX_WID - OFF_WID
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 miss_valid_i,
    input  logic [ADDR_WID-1:0]  miss_addr_i,
    output logic                 miss_ready_o,
    output logic                 mem_req_valid_o,
    output logic [ADDR_WID-1:0]  mem_req_addr_o,
    input  logic                 mem_req_ready_i,
    input  logic                 mem_rvalid_i,
    input  logic [DATA_WID-1:0]  mem_rdata_i,
    input  logic                 mem_rlast_i,
    output logic                 line_we_o,
    output logic [INDEX_WID-1:0] line_index_o,
    output logic [WORD_WID-1:0]  line_word_o,
    output logic [DATA_WID-1:0]  line_wdata_o,
    output logic                 tag_we_o,
    output logic [INDEX_WID-1:0] tag_index_o,
    output logic [TAG_WID:0]     tag_wdata_o,
    output logic                 refill_done_o,
    output logic                 refill_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INVAL,
        S_REQ,
        S_FILL,
        S_COMMIT
    } state_t;

    localparam logic [ADDR_WID-1:0] OFF_MASK =
        {{(ADDR_WID - OFF_WID){1'b0}}, {OFF_WID{1'b1}}};

    state_t              state_q;
    logic [WORD_WID-1:0] cnt_q;
    logic [ADDR_WID-1:0] addr_q;
    logic                err_q;

    logic               beat;
    logic               last_cnt;
    logic [TAG_WID-1:0] tag;

    assign beat     = (state_q == S_FILL) && mem_rvalid_i;
    assign last_cnt = &cnt_q;
    assign tag      = addr_q[ADDR_WID-1 -: TAG_WID];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (miss_valid_i) begin
                        addr_q  <= miss_addr_i;
                        state_q <= S_INVAL;
                    end
                end
                S_INVAL: begin
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (mem_req_ready_i) begin
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_rvalid_i) begin
                        if (last_cnt && mem_rlast_i) begin
                            state_q <= S_COMMIT;
                        end else if (last_cnt || mem_rlast_i) begin
                            // Short or overlong burst: tag stays invalid.
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                            err_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign miss_ready_o    = (state_q == S_IDLE);
    assign mem_req_valid_o = (state_q == S_REQ);
    assign mem_req_addr_o  = addr_q & ~OFF_MASK;

    // Beats are written in the cycle they arrive; no staging register.
    assign line_we_o    = beat;
    assign line_index_o = addr_q[OFF_WID +: INDEX_WID];
    assign line_word_o  = cnt_q;
    assign line_wdata_o = beat ? mem_rdata_i : '0;

    assign tag_we_o      = (state_q == S_INVAL) || (state_q == S_COMMIT);
    assign tag_index_o   = addr_q[OFF_WID +: INDEX_WID];
    assign tag_wdata_o   = {(state_q == S_COMMIT), tag};
    assign refill_done_o = (state_q == S_COMMIT);
    assign refill_err_o  = err_q;

endmodule
